// File: rtl/wb_stage_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : wb_stage_seq_pkg
// Purpose : Shared encodings for the write-back stage: result-source selects,
//           load funct3 codes and the write-back FSM state type.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package wb_stage_seq_pkg;

  // Result source select driven by the MEM stage
  localparam logic [1:0] FROM_ALU = 2'd0;
  localparam logic [1:0] FROM_MEM = 2'd1;
  localparam logic [1:0] FROM_IMM = 2'd2;
  localparam logic [1:0] FROM_PC  = 2'd3;

  // Load size / sign codes (funct3 of the load instruction)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Write-back sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    DRAIN    = 2'd2
  } wb_state_e;

endpackage : wb_stage_seq_pkg
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// Module  : wb_load_align
// Purpose : Combinational load data aligner. Picks the byte / half / word
//           addressed by addr_lo out of the raw memory word and sign- or
//           zero-extends it to XLEN according to funct3.
// Ports   : raw_i     [XLEN-1:0]  raw aligned word/dword from data memory
//           funct3_i  [2:0]       load size/sign code
//           addr_lo_i [AL-1:0]    low byte-address bits of the load
//           data_o    [XLEN-1:0]  aligned, extended load result
// Rev     : 1.0  initial release
// ============================================================================
module wb_load_align
  import wb_stage_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AL   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [2:0]      funct3_i,
  input  logic [AL-1:0]   addr_lo_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] w_b_sh;
  logic [XLEN-1:0] w_h_sh;
  logic [XLEN-1:0] w_lw;
  logic [XLEN-1:0] w_ld;
  logic [XLEN-1:0] w_lwu;

  // Byte lane uses every addr_lo bit; half lane ignores bit 0 so a
  // misaligned half simply reads the enclosing aligned half.
  assign w_b_sh = raw_i >> {addr_lo_i, 3'b000};
  assign w_h_sh = raw_i >> {addr_lo_i[AL-1:1], 4'b0000};

  generate
    if (XLEN == 64) begin : g_xlen64
      logic [XLEN-1:0] w_w_sh;
      // Word lane selected by the top address bit only
      assign w_w_sh = raw_i >> {addr_lo_i[AL-1], 5'b00000};
      assign w_lw   = {{(XLEN-32){w_w_sh[31]}}, w_w_sh[31:0]};
      assign w_lwu  = {{(XLEN-32){1'b0}},       w_w_sh[31:0]};
      assign w_ld   = raw_i;
    end else begin : g_xlen32
      // LD and LWU do not exist on a 32-bit datapath and read as zero
      assign w_lw  = raw_i;
      assign w_lwu = '0;
      assign w_ld  = '0;
    end
  endgenerate

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){w_b_sh[7]}},   w_b_sh[7:0]};
      F3_LH:   data_o = {{(XLEN-16){w_h_sh[15]}}, w_h_sh[15:0]};
      F3_LW:   data_o = w_lw;
      F3_LD:   data_o = w_ld;
      F3_LBU:  data_o = {{(XLEN-8){1'b0}},        w_b_sh[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}},       w_h_sh[15:0]};
      F3_LWU:  data_o = w_lwu;
      default: data_o = '0;
    endcase
  end

endmodule : wb_load_align
`default_nettype wire

// File: rtl/wb_stage_seq.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage_seq
// Purpose : Registered write-back stage. Accepts one retiring instruction per
//           cycle from MEM, selects ALU / memory / immediate / next-PC result,
//           waits for variable-latency load data and drives a registered
//           register-file write port.
// Ports   : clk, rst_n                   clock, async active-low reset
//           in_valid / in_ready          MEM -> WB handshake
//           in_reg_src, in_reg_we, in_rd instruction write-back control
//           in_alu_result, in_imm,
//           in_nxpc, in_funct3           result candidates / load info
//           flush                        kill presented beat and pending load
//           mem_rsp_valid, mem_rsp_data  load response
//           rf_we, rf_waddr, rf_wdata    registered register-file write
//           busy                         load outstanding
//           retire_cnt                   committed-instruction counter
//           err_rsp                      sticky unsolicited-response flag
// Rev     : 1.0  initial release
// ============================================================================
module wb_stage_seq
  import wb_stage_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_reg_src,
  input  logic                  in_reg_we,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_alu_result,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [XLEN-1:0]       in_nxpc,
  input  logic [2:0]            in_funct3,
  input  logic                  flush,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rsp_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  busy,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic                  err_rsp
);

  localparam int AL = $clog2(XLEN/8);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  wb_state_e               state_q;
  logic [REG_ADDR_W-1:0]   ld_rd_q;
  logic                    ld_we_q;
  logic [2:0]              ld_f3_q;
  logic [AL-1:0]           ld_lo_q;
  logic                    rf_we_q;
  logic [REG_ADDR_W-1:0]   rf_waddr_q;
  logic [XLEN-1:0]         rf_wdata_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    err_q;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                    w_accept;
  logic                    w_is_load;
  logic [XLEN-1:0]         w_sel_data;
  logic [XLEN-1:0]         w_ld_data;

  assign w_accept  = in_valid && (state_q == IDLE) && !flush;
  assign w_is_load = (in_reg_src == FROM_MEM);

  always_comb begin
    w_sel_data = in_alu_result;
    case (in_reg_src)
      FROM_ALU: w_sel_data = in_alu_result;
      FROM_IMM: w_sel_data = in_imm;
      FROM_PC:  w_sel_data = in_nxpc;
      default:  w_sel_data = in_alu_result;
    endcase
  end

  // Alignment runs off the latched load context, so the raw response is
  // the only live input at the response edge.
  wb_load_align #(
    .XLEN (XLEN),
    .AL   (AL)
  ) u_align (
    .raw_i     (mem_rsp_data),
    .funct3_i  (ld_f3_q),
    .addr_lo_i (ld_lo_q),
    .data_o    (w_ld_data)
  );

  // --------------------------------------------------------------------------
  // FSM, load context, write port and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_rd_q    <= '0;
      ld_we_q    <= 1'b0;
      ld_f3_q    <= '0;
      ld_lo_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      // Write enable is a one-cycle pulse; address/data hold otherwise.
      rf_we_q <= 1'b0;

      case (state_q)
        IDLE: begin
          // Nothing is outstanding, so any response here is unsolicited.
          if (mem_rsp_valid) begin
            err_q <= 1'b1;
          end
          if (w_accept) begin
            if (w_is_load) begin
              ld_rd_q <= in_rd;
              ld_we_q <= in_reg_we;
              ld_f3_q <= in_funct3;
              ld_lo_q <= in_alu_result[AL-1:0];
              state_q <= WAIT_MEM;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
              // x0 retires but never reaches the register file
              if (in_reg_we && (in_rd != '0)) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= in_rd;
                rf_wdata_q <= w_sel_data;
              end
            end
          end
        end

        WAIT_MEM: begin
          if (mem_rsp_valid) begin
            // A flush coinciding with the response kills it outright.
            state_q <= IDLE;
            if (!flush) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (ld_we_q && (ld_rd_q != '0)) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= ld_rd_q;
                rf_wdata_q <= w_ld_data;
              end
            end
          end else if (flush) begin
            // Memory still owes a response; swallow it in DRAIN.
            state_q <= DRAIN;
          end
        end

        DRAIN: begin
          if (mem_rsp_valid) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign retire_cnt = cnt_q;
  assign err_rsp    = err_q;

endmodule : wb_stage_seq
`default_nettype wire

// File: tb/tb_wb_stage_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage_seq
// Purpose : Self-checking bench for wb_stage_seq (XLEN=32) with directed
//           scenarios and a randomized run against a behavioural model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_stage_seq;
  import wb_stage_seq_pkg::*;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int CW   = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_reg_src;
  logic            in_reg_we;
  logic [RAW-1:0]  in_rd;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_nxpc;
  logic [2:0]      in_funct3;
  logic            flush;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            rf_we;
  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic [CW-1:0]   retire_cnt;
  logic            err_rsp;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int unsigned     exp_cnt;
  logic [RAW-1:0]  last_waddr;
  logic [XLEN-1:0] last_wdata;

  wb_stage_seq #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_src    (in_reg_src),
    .in_reg_we     (in_reg_we),
    .in_rd         (in_rd),
    .in_alu_result (in_alu_result),
    .in_imm        (in_imm),
    .in_nxpc       (in_nxpc),
    .in_funct3     (in_funct3),
    .flush         (flush),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .busy          (busy),
    .retire_cnt    (retire_cnt),
    .err_rsp       (err_rsp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load result from little-endian byte/half extraction rules.
  function automatic logic [31:0] ref_load(logic [31:0] raw, logic [2:0] f3, logic [1:0] lo);
    longint unsigned b, h;
    int sb, sh;
    sb = int'(lo) * 8;
    sh = (int'(lo) / 2) * 16;
    b  = longint'(raw >> sb) % 256;
    h  = longint'(raw >> sh) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd2:    return raw;
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat for exactly one edge, then withdraw it.
  task automatic issue_beat(input logic [1:0] src, input logic we, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [31:0] imm,
                            input logic [31:0] nxpc, input logic [2:0] f3, input logic fl);
    in_valid = 1'b1; in_reg_src = src; in_reg_we = we; in_rd = rd;
    in_alu_result = alu; in_imm = imm; in_nxpc = nxpc; in_funct3 = f3; flush = fl;
    step();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic send_rsp(input logic [31:0] data, input logic fl);
    mem_rsp_valid = 1'b1; mem_rsp_data = data; flush = fl;
    step();
    mem_rsp_valid = 1'b0; flush = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_reg_src = 0; in_reg_we = 0; in_rd = 0; in_alu_result = 0;
    in_imm = 0; in_nxpc = 0; in_funct3 = 0; flush = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    repeat (2) step();
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, busy, err_rsp} !== '0 || retire_cnt !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: we=%0b waddr=%0d wdata=%h busy=%0b err=%0b cnt=%0d rdy=%0b, want all 0 and rdy=1",
               rf_we, rf_waddr, rf_wdata, busy, err_rsp, retire_cnt, in_ready);
    end
    rst_n = 1'b1;
    exp_cnt = 0; last_waddr = 0; last_wdata = 0;
    step();
  endtask

  task automatic test_back_to_back();
    issue_beat(FROM_ALU, 1'b1, 5'd3, 32'h11, 32'h0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      n_bad++;
      $display("FAIL b2b_first: we=%0b waddr=%0d wdata=%h, want 1/3/00000011", rf_we, rf_waddr, rf_wdata);
    end
    issue_beat(FROM_ALU, 1'b1, 5'd4, 32'h22, 32'h0, 32'h0, 3'd0, 1'b0);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      n_bad++;
      $display("FAIL b2b_second: we=%0b waddr=%0d wdata=%h, want 1/4/00000022", rf_we, rf_waddr, rf_wdata);
    end
    step();
    exp_cnt += 2; last_waddr = 4; last_wdata = 32'h22;
    n_cmp++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22 || retire_cnt !== CW'(exp_cnt)) begin
      n_bad++;
      $display("FAIL b2b_idle_hold: we=%0b waddr=%0d wdata=%h cnt=%0d, want 0/4/00000022/%0d",
               rf_we, rf_waddr, rf_wdata, retire_cnt, exp_cnt);
    end
    // IMM and next-PC source selects
    issue_beat(FROM_IMM, 1'b1, 5'd7, 32'hAAAA_0000, 32'h1234_5000, 32'h0000_0104, 3'd0, 1'b0);
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234_5000) begin
      n_bad++;
      $display("FAIL sel_imm: we=%0b waddr=%0d wdata=%h, want 1/7/12345000", rf_we, rf_waddr, rf_wdata);
    end
    issue_beat(FROM_PC, 1'b1, 5'd1, 32'hAAAA_0000, 32'h1234_5000, 32'h0000_0104, 3'd0, 1'b0);
    exp_cnt += 2; last_waddr = 1; last_wdata = 32'h104;
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h104 || retire_cnt !== CW'(exp_cnt)) begin
      n_bad++;
      $display("FAIL sel_pc: we=%0b waddr=%0d wdata=%h cnt=%0d, want 1/1/00000104/%0d",
               rf_we, rf_waddr, rf_wdata, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_load_lb();
    int low_cnt;
    logic [1:0] lo;
    logic [31:0] exp;
    for (int k = 0; k < 2; k++) begin
      lo  = (k == 0) ? 2'd3 : 2'd2;
      exp = ref_load(32'h80FF_0000, 3'd0, lo);
      issue_beat(FROM_MEM, 1'b1, 5'd9, {30'h400, lo}, 32'h0, 32'h0, 3'd0, 1'b0);
      low_cnt = 0;
      n_cmp++;
      if (rf_we !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL lb_accept: we=%0b busy=%0b, want 0/1", rf_we, busy);
      end
      for (int c = 0; c < 3; c++) begin
        if (in_ready === 1'b0) low_cnt++;
        if (c < 2) step();
      end
      n_cmp++;
      if (low_cnt !== 3) begin
        n_bad++;
        $display("FAIL lb_ready_low: cycles=%0d, want 3", low_cnt);
      end
      send_rsp(32'h80FF_0000, 1'b0);
      exp_cnt++; last_waddr = 9; last_wdata = exp;
      n_cmp++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== exp || retire_cnt !== CW'(exp_cnt) || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL lb_write lo=%0d: we=%0b waddr=%0d wdata=%h cnt=%0d rdy=%0b, want 1/9/%h/%0d/1",
                 lo, rf_we, rf_waddr, rf_wdata, retire_cnt, in_ready, exp, exp_cnt);
      end
    end
  endtask

  task automatic test_load_half();
    logic [2:0]  f3s [3];
    logic [4:0]  rds [3];
    logic [31:0] exp;
    f3s = '{3'd5, 3'd1, 3'd2};
    rds = '{5'd10, 5'd11, 5'd0};
    for (int k = 0; k < 3; k++) begin
      exp = ref_load(32'h8001_1234, f3s[k], 2'd2);
      issue_beat(FROM_MEM, 1'b1, rds[k], 32'h0000_2002, 32'h0, 32'h0, f3s[k], 1'b0);
      send_rsp(32'h8001_1234, 1'b0);
      exp_cnt++;
      if (rds[k] != 0) begin last_waddr = rds[k]; last_wdata = exp; end
      n_cmp++;
      if (rf_we !== (rds[k] != 0) || rf_waddr !== last_waddr || rf_wdata !== last_wdata ||
          retire_cnt !== CW'(exp_cnt)) begin
        n_bad++;
        $display("FAIL half_load f3=%0d rd=%0d: we=%0b waddr=%0d wdata=%h cnt=%0d, want %0b/%0d/%h/%0d",
                 f3s[k], rds[k], rf_we, rf_waddr, rf_wdata, retire_cnt,
                 (rds[k] != 0), last_waddr, last_wdata, exp_cnt);
      end
    end
  endtask

  task automatic test_flush();
    // Flush while waiting, response two cycles later
    issue_beat(FROM_MEM, 1'b1, 5'd12, 32'h0, 32'h0, 32'h0, 3'd2, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || rf_we !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_drain: busy=%0b rdy=%0b we=%0b, want 1/0/0", busy, in_ready, rf_we);
    end
    step();
    send_rsp(32'hDEAD_BEEF, 1'b0);
    n_cmp++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || retire_cnt !== CW'(exp_cnt) ||
        rf_wdata !== last_wdata || err_rsp !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_discard: we=%0b busy=%0b rdy=%0b cnt=%0d wdata=%h err=%0b, want 0/0/1/%0d/%h/0",
               rf_we, busy, in_ready, retire_cnt, rf_wdata, err_rsp, exp_cnt, last_wdata);
    end
    // Flush coinciding with the response
    issue_beat(FROM_MEM, 1'b1, 5'd13, 32'h0, 32'h0, 32'h0, 3'd2, 1'b0);
    send_rsp(32'hCAFE_F00D, 1'b1);
    n_cmp++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || retire_cnt !== CW'(exp_cnt)) begin
      n_bad++;
      $display("FAIL flush_same_cycle: we=%0b busy=%0b cnt=%0d, want 0/0/%0d", rf_we, busy, retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_err_and_flush_beat();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5;
    step();
    mem_rsp_valid = 1'b0;
    step();
    step();
    n_cmp++;
    if (err_rsp !== 1'b1 || rf_we !== 1'b0 || retire_cnt !== CW'(exp_cnt)) begin
      n_bad++;
      $display("FAIL err_sticky: err=%0b we=%0b cnt=%0d, want 1/0/%0d", err_rsp, rf_we, retire_cnt, exp_cnt);
    end
    issue_beat(FROM_PC, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0000_0200, 3'd0, 1'b1);
    n_cmp++;
    if (rf_we !== 1'b0 || retire_cnt !== CW'(exp_cnt) || rf_wdata !== last_wdata || err_rsp !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_beat: we=%0b cnt=%0d wdata=%h err=%0b, want 0/%0d/%h/1",
               rf_we, retire_cnt, rf_wdata, err_rsp, exp_cnt, last_wdata);
    end
  endtask

  task automatic test_reset_midload();
    issue_beat(FROM_MEM, 1'b1, 5'd14, 32'h0, 32'h0, 32'h0, 3'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rf_we, rf_waddr, rf_wdata, busy, err_rsp} !== '0 || retire_cnt !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_midload: we=%0b waddr=%0d wdata=%h busy=%0b err=%0b cnt=%0d rdy=%0b, want all 0 and rdy=1",
               rf_we, rf_waddr, rf_wdata, busy, err_rsp, retire_cnt, in_ready);
    end
    #1;
    rst_n = 1'b1;
    exp_cnt = 0; last_waddr = 0; last_wdata = 0;
    step();
  endtask

  task automatic test_random();
    logic [2:0]  f3_pool [8];
    logic [1:0]  src;
    logic        we, fl, exp_we;
    logic [4:0]  rd;
    logic [31:0] alu, imm, nx, raw, exp;
    logic [2:0]  f3;
    int          mode, dly;
    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int it = 0; it < 60; it++) begin
      src = 2'($urandom_range(0, 3));
      we  = ($urandom % 4) != 0;
      rd  = 5'($urandom);
      alu = $urandom; imm = $urandom; nx = $urandom; raw = $urandom;
      f3  = f3_pool[$urandom % 8];
      if (src != FROM_MEM) begin
        fl = ($urandom % 6) == 0;
        issue_beat(src, we, rd, alu, imm, nx, f3, fl);
        exp_we = !fl && we && (rd != 0);
        if (!fl) exp_cnt++;
        if (exp_we) begin
          last_waddr = rd;
          last_wdata = (src == FROM_ALU) ? alu : (src == FROM_IMM) ? imm : nx;
        end
      end else begin
        mode = $urandom % 5;   // 0-2 normal, 3 flush while waiting, 4 flush with response
        dly  = $urandom_range(0, 3);
        issue_beat(src, we, rd, alu, imm, nx, f3, 1'b0);
        // Junk beats offered while the stage is busy must not be taken
        in_reg_src = FROM_ALU; in_reg_we = 1'b1; in_rd = 5'd5; in_alu_result = 32'hBAD0_BAD0;
        if (mode == 3) begin
          in_valid = $urandom % 2; flush = 1'b1;
          step();
          flush = 1'b0;
        end
        for (int c = 0; c < dly; c++) begin
          in_valid = $urandom % 2;
          step();
        end
        send_rsp(raw, mode == 4);
        in_valid = 1'b0;
        exp    = ref_load(raw, f3, alu[1:0]);
        exp_we = (mode < 3) && we && (rd != 0);
        if (mode < 3) exp_cnt++;
        if (exp_we) begin last_waddr = rd; last_wdata = exp; end
      end
      n_cmp++;
      if (rf_we !== exp_we || rf_waddr !== last_waddr || rf_wdata !== last_wdata ||
          retire_cnt !== CW'(exp_cnt) || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL random it=%0d src=%0d f3=%0d rd=%0d: we=%0b waddr=%0d wdata=%h cnt=%0d rdy=%0b, want %0b/%0d/%h/%0d/1",
                 it, src, f3, rd, rf_we, rf_waddr, rf_wdata, retire_cnt, in_ready,
                 exp_we, last_waddr, last_wdata, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_lb();
    test_load_half();
    test_flush();
    test_err_and_flush_beat();
    test_reset_midload();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_wb_stage_seq
`default_nettype wire
